// File: rtl/i2s_slave.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_slave
//  Purpose  : I2S slave port. sclk/lrck/sdin come from an external I2S clock
//             master and are oversampled on the system clock. The block
//             deserialises sdin into left/right words and serialises a
//             supplied stereo pair onto sdout. clk must be at least 8x sclk.
//  Ports    : clk, rst (async, active-low)
//             sclk, lrck, sdin           - external I2S lines (lrck 0 = left)
//             sdout                      - serial data out, updated after sclk fall
//             out_ready                  - 1-clk pulse, new frame on out_data_l/r
//             out_data_l, out_data_r     - received words
//             in_data_l, in_data_r       - words to transmit
//             in_load                    - 1-clk pulse, in_data_l/r latched
//             locked                     - high after a complete valid L+R frame
//             frame_err                  - 1-clk pulse on a short channel
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_slave #(
  parameter int DATA_BITS   = 24,
  parameter int SLOT_BITS   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 lrck,
  input  logic                 sdin,
  output logic                 sdout,
  output logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data_l,
  output logic [DATA_BITS-1:0] out_data_r,
  input  logic [DATA_BITS-1:0] in_data_l,
  input  logic [DATA_BITS-1:0] in_data_r,
  output logic                 in_load,
  output logic                 locked,
  output logic                 frame_err
);

  localparam logic [SLOT_BITS-1:0] c_slot_max    = '1;
  localparam logic [SLOT_BITS-1:0] c_slot_one    = SLOT_BITS'(1);
  localparam logic [SLOT_BITS-1:0] c_data_bits   = SLOT_BITS'(DATA_BITS);
  localparam logic [SLOT_BITS:0]   c_data_bits_x = (SLOT_BITS+1)'(DATA_BITS);
  localparam logic [SLOT_BITS:0]   c_one_x       = (SLOT_BITS+1)'(1);
  localparam logic [DATA_BITS-1:0] c_bit0        = DATA_BITS'(1);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_sdin_sync;
  logic                   r_sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_lrck_sync <= '0;
      r_sdin_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync[0] <= sclk;
      r_lrck_sync[0] <= lrck;
      r_sdin_sync[0] <= sdin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_lrck_sync[i] <= r_lrck_sync[i-1];
        r_sdin_sync[i] <= r_sdin_sync[i-1];
      end
      r_sclk_d <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s;
  logic w_lrck_s;
  logic w_sdin_s;
  logic w_rise;
  logic w_fall;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_lrck_s = r_lrck_sync[SYNC_STAGES-1];
  assign w_sdin_s = r_sdin_sync[SYNC_STAGES-1];
  assign w_rise   =  w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s &  r_sclk_d;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SLOT_BITS-1:0] r_slot;
  logic                 r_lrck_prev;   // lrck as sampled on the previous rise
  logic                 r_armed;       // set by the first lrck 1->0 boundary
  logic                 r_left_valid;
  logic                 r_rx_pend;     // right word complete, publish next clk
  logic [DATA_BITS-1:0] r_shift_l;
  logic [DATA_BITS-1:0] r_shift_r;
  logic [DATA_BITS-1:0] r_hold_l;
  logic [DATA_BITS-1:0] r_tx_l;
  logic [DATA_BITS-1:0] r_tx_r;
  logic [DATA_BITS-1:0] r_out_l;
  logic [DATA_BITS-1:0] r_out_r;
  logic                 r_out_ready;
  logic                 r_in_load;
  logic                 r_locked;
  logic                 r_frame_err;
  logic                 r_sdout;

  // --------------------------------------------------------------------------
  // Slot / framing decode (valid on a rise)
  // --------------------------------------------------------------------------
  logic                 w_boundary;
  logic [SLOT_BITS-1:0] w_slot_next;
  logic                 w_data_slot;
  logic                 w_last_bit;
  logic                 w_short;
  logic [DATA_BITS-1:0] w_shift_l_next;
  logic [DATA_BITS-1:0] w_shift_r_next;

  assign w_boundary  = w_rise & (w_lrck_s != r_lrck_prev);
  assign w_slot_next = w_boundary             ? '0 :
                       (r_slot == c_slot_max) ? c_slot_max :
                                                r_slot + c_slot_one;
  assign w_data_slot = (w_slot_next != '0) && (w_slot_next <= c_data_bits);
  assign w_last_bit  = (w_slot_next == c_data_bits);
  // A boundary that cuts the previous channel inside its data bits.
  assign w_short     = w_boundary & r_armed & (r_slot != '0) & (r_slot < c_data_bits);

  assign w_shift_l_next = {r_shift_l[DATA_BITS-2:0], w_sdin_s};
  assign w_shift_r_next = {r_shift_r[DATA_BITS-2:0], w_sdin_s};

  // --------------------------------------------------------------------------
  // Transmit bit select: on a fall the bit for slot+1 is driven so that it is
  // stable at the master's next rise. slot+1 is computed one bit wider so a
  // saturated counter never wraps back into the data range.
  // --------------------------------------------------------------------------
  logic [SLOT_BITS:0]   w_tx_pos;
  logic [SLOT_BITS:0]   w_tx_idx;
  logic                 w_tx_in_range;
  logic [DATA_BITS-1:0] w_tx_word;
  logic                 w_tx_bit;

  assign w_tx_pos      = {1'b0, r_slot} + c_one_x;
  assign w_tx_in_range = (w_tx_pos <= c_data_bits_x);
  assign w_tx_idx      = c_data_bits_x - w_tx_pos;
  assign w_tx_word     = w_lrck_s ? r_tx_r : r_tx_l;
  assign w_tx_bit      = |(w_tx_word & (c_bit0 << w_tx_idx));

  // --------------------------------------------------------------------------
  // Main sequential process
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot       <= '0;
      r_lrck_prev  <= 1'b0;
      r_armed      <= 1'b0;
      r_left_valid <= 1'b0;
      r_rx_pend    <= 1'b0;
      r_shift_l    <= '0;
      r_shift_r    <= '0;
      r_hold_l     <= '0;
      r_tx_l       <= '0;
      r_tx_r       <= '0;
      r_out_l      <= '0;
      r_out_r      <= '0;
      r_out_ready  <= 1'b0;
      r_in_load    <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sdout      <= 1'b0;
    end else begin
      r_out_ready <= 1'b0;
      r_in_load   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_pend   <= 1'b0;

      if (w_rise) begin
        r_lrck_prev <= w_lrck_s;
        r_slot      <= w_slot_next;

        if (w_data_slot) begin
          if (w_lrck_s) r_shift_r <= w_shift_r_next;
          else          r_shift_l <= w_shift_l_next;
        end

        // Left boundary: arm capture and latch the next stereo pair to send.
        if (w_boundary && !w_lrck_s) begin
          r_armed   <= 1'b1;
          r_tx_l    <= in_data_l;
          r_tx_r    <= in_data_r;
          r_in_load <= 1'b1;
        end

        if (w_last_bit && !w_lrck_s && r_armed) begin
          r_hold_l     <= w_shift_l_next;
          r_left_valid <= 1'b1;
        end

        if (w_last_bit && w_lrck_s && r_left_valid) begin
          r_rx_pend    <= 1'b1;
          r_left_valid <= 1'b0;
        end

        // w_short only fires on a boundary (slot 0), so it never coincides
        // with the last-bit captures above.
        if (w_short) begin
          r_frame_err  <= 1'b1;
          r_locked     <= 1'b0;
          r_left_valid <= 1'b0;
        end
      end

      if (r_rx_pend) begin
        r_out_l     <= r_hold_l;
        r_out_r     <= r_shift_r;
        r_out_ready <= 1'b1;
        r_locked    <= 1'b1;
      end

      if (w_fall) begin
        r_sdout <= w_tx_in_range & w_tx_bit;
      end
    end
  end

  assign sdout      = r_sdout;
  assign out_ready  = r_out_ready;
  assign out_data_l = r_out_l;
  assign out_data_r = r_out_r;
  assign in_load    = r_in_load;
  assign locked     = r_locked;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_slave
//  Purpose  : Self-checking bench for i2s_slave. A simple I2S master model
//             drives sclk = clk/8 with 32 slots per channel, captures sdout at
//             each sclk rise, and a scoreboard queue holds expected frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        lrck = 1'b0;
  logic        sdin = 1'b0;
  logic [23:0] in_data_l = '0;
  logic [23:0] in_data_r = '0;
  logic        sdout;
  logic        out_ready;
  logic [23:0] out_data_l;
  logic [23:0] out_data_r;
  logic        in_load;
  logic        locked;
  logic        frame_err;

  always #5 clk = ~clk;

  i2s_slave #(
    .DATA_BITS  (24),
    .SLOT_BITS  (6),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .lrck      (lrck),
    .sdin      (sdin),
    .sdout     (sdout),
    .out_ready (out_ready),
    .out_data_l(out_data_l),
    .out_data_r(out_data_r),
    .in_data_l (in_data_l),
    .in_data_r (in_data_r),
    .in_load   (in_load),
    .locked    (locked),
    .frame_err (frame_err)
  );

  int          total = 0;
  int          bad = 0;
  int          n_ready = 0;
  int          n_load = 0;
  int          n_err = 0;
  logic [47:0] exp_q[$];
  logic [47:0] popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (in_load === 1'b1) n_load++;
    if (frame_err === 1'b1) n_err++;
    if (out_ready === 1'b1) begin
      n_ready++;
      check("ready_with_err", 32'(frame_err), 32'd0);
      check("ready_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        check("out_data_l", 32'(out_data_l), 32'(popped[47:24]));
        check("out_data_r", 32'(out_data_r), 32'(popped[23:0]));
      end
    end
  end

  // One sclk period: fall (master updates lrck/sdin), then rise (master
  // samples sdout).
  task automatic slot(input logic lr, input logic d, output logic so);
    sclk = 1'b0;
    lrck = lr;
    sdin = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    so   = sdout;
    repeat (4) @(negedge clk);
  endtask

  task automatic channel(input logic lr, input logic [23:0] word, input int first,
                         input int last, input bit rnd_pad, input bit chk_tx,
                         input logic [23:0] tx_exp);
    logic [23:0] cap;
    logic        so;
    logic        d;
    cap = '0;
    for (int s = first; s <= last; s++) begin
      if (s >= 1 && s <= 24) d = word[24-s];
      else                   d = rnd_pad ? 1'($urandom) : 1'b0;
      slot(lr, d, so);
      if (s >= 1 && s <= 24) cap[24-s] = so;
      else if (chk_tx) check($sformatf("sdout_pad_s%0d", s), 32'(so), 32'd0);
    end
    if (chk_tx) check(lr ? "tx_word_r" : "tx_word_l", 32'(cap), 32'(tx_exp));
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r, input bit push,
                       input bit rnd_pad, input bit chk_tx);
    channel(1'b0, l, 0, 31, rnd_pad, chk_tx, in_data_l);
    if (push) exp_q.push_back({l, r});
    channel(1'b1, r, 0, 31, rnd_pad, chk_tx, in_data_r);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_now_sdout", 32'(sdout), 32'd0);
    check("rst_now_out_l", 32'(out_data_l), 32'd0);
    check("rst_now_out_r", 32'(out_data_r), 32'd0);
    check("rst_now_locked", 32'(locked), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int l0;
  int r0;

  initial begin
    in_data_l = 24'hA5A5A5;
    in_data_r = 24'h5A5A5A;
    repeat (4) @(negedge clk);

    // Reset state
    check("reset_sdout", 32'(sdout), 32'd0);
    check("reset_out_ready", 32'(out_ready), 32'd0);
    check("reset_in_load", 32'(in_load), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_out_l", 32'(out_data_l), 32'd0);
    check("reset_out_r", 32'(out_data_r), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Unarmed right channel, then basic rx/tx frames
    channel(1'b1, 24'h000000, 0, 31, 1'b0, 1'b0, 24'h0);
    check("locked_before_first", 32'(locked), 32'd0);
    l0 = n_load;
    frame(24'h123456, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
    check("f1_drained", 32'(exp_q.size()), 32'd0);
    check("f1_locked", 32'(locked), 32'd1);
    check("f1_in_load_count", 32'(n_load - l0), 32'd1);
    l0 = n_load;
    frame(24'h123456, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
    check("f2_drained", 32'(exp_q.size()), 32'd0);
    check("f2_in_load_count", 32'(n_load - l0), 32'd1);
    check("f2_ready_count", 32'(n_ready), 32'd2);

    // Random data in padding and delay slots
    frame(24'h123456, 24'hABCDEF, 1'b1, 1'b1, 1'b0);
    check("pad_drained", 32'(exp_q.size()), 32'd0);
    check("pad_out_l", 32'(out_data_l), 32'h123456);
    check("pad_out_r", 32'(out_data_r), 32'hABCDEF);

    // Short left channel (lrck toggles after slot 10)
    r0 = n_ready;
    check("short_locked_before", 32'(locked), 32'd1);
    channel(1'b0, 24'h123456, 0, 10, 1'b0, 1'b0, 24'h0);
    channel(1'b1, 24'hABCDEF, 0, 31, 1'b0, 1'b0, 24'h0);
    check("short_err_count", 32'(n_err), 32'd1);
    check("short_locked", 32'(locked), 32'd0);
    check("short_no_ready", 32'(n_ready - r0), 32'd0);
    frame(24'h13579B, 24'h2468AC, 1'b1, 1'b0, 1'b0);
    check("short_recover_drained", 32'(exp_q.size()), 32'd0);
    check("short_recover_locked", 32'(locked), 32'd1);

    // Reset during left slot 12
    in_data_l = 24'hFFFFFF;
    channel(1'b0, 24'h111111, 0, 12, 1'b0, 1'b0, 24'h0);
    check("pre_rst_sdout", 32'(sdout), 32'd1);
    pulse_reset();
    r0 = n_ready;
    channel(1'b0, 24'h111111, 13, 31, 1'b0, 1'b0, 24'h0);
    channel(1'b1, 24'h222222, 0, 31, 1'b0, 1'b0, 24'h0);
    check("midl_no_ready", 32'(n_ready - r0), 32'd0);
    check("midl_locked", 32'(locked), 32'd0);
    in_data_l = 24'hA5A5A5;
    frame(24'h0F1E2D, 24'h3C4B5A, 1'b1, 1'b0, 1'b0);
    check("midl_drained", 32'(exp_q.size()), 32'd0);
    check("midl_locked_after", 32'(locked), 32'd1);

    // Reset during right channel after a full left
    channel(1'b0, 24'h123456, 0, 31, 1'b0, 1'b0, 24'h0);
    channel(1'b1, 24'hABCDEF, 0, 9, 1'b0, 1'b0, 24'h0);
    pulse_reset();
    r0 = n_ready;
    channel(1'b1, 24'hABCDEF, 10, 31, 1'b0, 1'b0, 24'h0);
    check("midr_no_ready", 32'(n_ready - r0), 32'd0);
    check("midr_locked", 32'(locked), 32'd0);
    frame(24'h2C3D4E, 24'h5F6071, 1'b1, 1'b0, 1'b1);
    check("midr_drained", 32'(exp_q.size()), 32'd0);
    check("midr_locked_after", 32'(locked), 32'd1);
    check("midr_ready_count", 32'(n_ready - r0), 32'd1);

    check("total_frame_err", 32'(n_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
